// File: rtl/apb_cmd_master_if.sv
// Bundles the command, APB requester/completer and response signals of apb_cmd_master.
// Latency: none; this file holds wires only.
// Backpressure: cmd_ready/rsp_ready travel opposite to their valids; PREADY stalls the APB side.
interface apb_cmd_master_if;
  // command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;

  // APB requester outputs
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;

  // APB completer inputs
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Queues read/write commands in a FIFO and issues them one at a time as APB transfers.
// Latency: command accepted at edge N is popped at N+1, response valid at edge N+3 when PREADY=1.
// Backpressure: cmd_ready = FIFO not full (registered); no transfer starts while a response waits.
module apb_cmd_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_cmd_master_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // ---------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------
  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  // ---------------------------------------------------------------
  // FSM, APB request and response state
  // ---------------------------------------------------------------
  state_t        state;
  state_t        state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          psel;
  logic          penable;
  logic          xfer_done;
  logic          xfer_tmo;

  logic          pwrite_q;
  logic [31:0]   paddr_q;
  logic [31:0]   pwdata_q;

  logic          rsp_vld_q;
  logic          rsp_write_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic          rsp_tmo_q;

  // Ready depends only on the registered occupancy so there is no path from cmd_valid or PREADY.
  assign bus.cmd_ready = (count != FIFO_FULL);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign fifo_empty    = (count == '0);
  assign head          = fifo_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array is write-only from the command side; contents are don't-care until pushed.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start only when a command waits and the previous response has been taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty && !rsp_vld_q) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY || (wait_cnt == WAIT_LAST)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State-decoded APB strobes plus the pop / completion / timeout pulses for the datapath.
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    pop       = 1'b0;
    xfer_done = 1'b0;
    xfer_tmo  = 1'b0;
    case (state)
      IDLE: begin
        pop = !fifo_empty && !rsp_vld_q;
      end
      SETUP: begin
        psel = 1'b1;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        xfer_done = bus.PREADY;
        xfer_tmo  = !bus.PREADY && (wait_cnt == WAIT_LAST);
      end
      default: begin
        psel = 1'b0;
      end
    endcase
  end

  assign bus.PSEL    = psel;
  assign bus.PENABLE = penable;

  // Counts stalled ACCESS cycles; cleared outside ACCESS so each transfer gets a fresh budget.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if ((state != ACCESS) || bus.PREADY || xfer_tmo) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Address/control/data load on pop and hold through the transfer and the following idle time.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (pop) begin
      pwrite_q <= head.write;
      paddr_q  <= head.addr;
      pwdata_q <= head.wdata;
    end
  end

  assign bus.PWRITE = pwrite_q;
  assign bus.PADDR  = paddr_q;
  assign bus.PWDATA = pwdata_q;

  // Response register: captured at completion or timeout, held until the consumer takes it.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_vld_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else if (xfer_done) begin
      rsp_vld_q   <= 1'b1;
      rsp_write_q <= pwrite_q;
      rsp_rdata_q <= pwrite_q ? 32'h0 : bus.PRDATA;
      rsp_err_q   <= bus.PSLVERR;
      rsp_tmo_q   <= 1'b0;
    end else if (xfer_tmo) begin
      rsp_vld_q   <= 1'b1;
      rsp_write_q <= pwrite_q;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b1;
      rsp_tmo_q   <= 1'b1;
    end else if (rsp_vld_q && bus.rsp_ready) begin
      rsp_vld_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_vld_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small APB completer model and a response log.
// Latency: checks exact cycle placement of the first transfer, then bounded waits elsewhere.
// Backpressure: exercises full FIFO, stalled PREADY, held rsp_ready and reset mid-transfer.
module tb_apb_cmd_master;

  logic PCLK;
  logic PRESET;
  int   checks = 0;
  int   errors = 0;

  apb_cmd_master_if bus ();

  apb_cmd_master #(.DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // completer model: programmable wait states, hang and error
  logic [31:0] mem [16];
  int          acc_cnt;
  int          slv_wait;
  bit          slv_hang;
  bit          slv_err;

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && !slv_hang && (acc_cnt >= slv_wait);
  assign bus.PRDATA  = mem[bus.PADDR[5:2]];
  assign bus.PSLVERR = slv_err && bus.PREADY;

  // register file and wait-state counter of the completer
  always @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'hDEAD_0000;
      mem[1]  <= 32'h0000_0001;
      mem[2]  <= 32'h0000_000F;
      acc_cnt <= 0;
    end else begin
      if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
        mem[bus.PADDR[5:2]] <= bus.PWDATA;
    end
  end

  // response log {write, err, timeout, rdata}
  logic [34:0] rsp_q [$];
  always @(posedge PCLK) begin
    if (!PRESET && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back({bus.rsp_write, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata});
  end

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.cmd_ready) ok = 1'b1;
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("push_accepted", 35'(ok), 35'(1));
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && rsp_q.size() < n; i++) step();
    chk("rsp_count", 35'(rsp_q.size()), 35'(n));
  endtask

  task automatic wait_access();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.PSEL && bus.PENABLE) seen = 1'b1;
      else step();
    end
    chk("access_seen", 35'(seen), 35'(1));
  endtask

  initial begin
    int base;
    int acc;

    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    slv_wait      = 0;
    slv_hang      = 1'b0;
    slv_err       = 1'b0;
    step();
    step();
    PRESET = 1'b0;

    // reset values
    chk("rst_penable", 35'(bus.PENABLE), 35'(0));
    chk("rst_pwrite",  35'(bus.PWRITE),  35'(0));
    chk("rst_paddr",   35'(bus.PADDR),   35'(0));
    chk("rst_pwdata",  35'(bus.PWDATA),  35'(0));
    chk("rst_rsp", {bus.rsp_write, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 35'(0));
    for (int i = 0; i < 10; i++) begin
      chk("idle_psel",      35'(bus.PSEL),      35'(0));
      chk("idle_cmd_ready", 35'(bus.cmd_ready), 35'(1));
      chk("idle_rsp_valid", 35'(bus.rsp_valid), 35'(0));
      step();
    end

    // write 0x0 = 0xF, then read 0x8; exact cycle placement of the first transfer
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0000_000F;
    step();
    chk("no_bypass_psel", 35'(bus.PSEL), 35'(0));
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h8;
    bus.cmd_wdata = 32'h0;
    step();
    bus.cmd_valid = 1'b0;
    chk("setup_psel_en", 35'({bus.PSEL, bus.PENABLE}), 35'(2'b10));
    chk("setup_paddr",   35'(bus.PADDR),  35'(0));
    chk("setup_pwrite",  35'(bus.PWRITE), 35'(1));
    chk("setup_pwdata",  35'(bus.PWDATA), 35'(32'hF));
    step();
    chk("access_psel_en", 35'({bus.PSEL, bus.PENABLE}), 35'(2'b11));
    step();
    chk("lat_rsp_valid", 35'(bus.rsp_valid), 35'(1));
    chk("lat_psel",      35'(bus.PSEL),      35'(0));
    wait_rsp(2);
    chk("wr_rsp", rsp_q[0], {1'b1, 1'b0, 1'b0, 32'h0});
    chk("rd_rsp", rsp_q[1], {1'b0, 1'b0, 1'b0, 32'h0000_000F});

    // five back-to-back commands into a DEPTH=4 FIFO behind a stalled completer
    base     = rsp_q.size();
    slv_hang = 1'b1;
    push(1'b1, 32'h20, 32'hA5);
    push(1'b1, 32'h24, 32'h5A);
    push(1'b0, 32'h20, 32'h0);
    push(1'b0, 32'h24, 32'h0);
    push(1'b1, 32'h28, 32'h1234);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h3C;
    bus.cmd_wdata = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      chk("full_cmd_ready", 35'(bus.cmd_ready), 35'(0));
      chk("stall_access", 35'({bus.PSEL, bus.PENABLE}), 35'(2'b11));
      step();
    end
    bus.cmd_valid = 1'b0;
    slv_hang      = 1'b0;
    wait_rsp(base + 5);
    chk("order_0", rsp_q[base + 0], {1'b1, 1'b0, 1'b0, 32'h0});
    chk("order_1", rsp_q[base + 1], {1'b1, 1'b0, 1'b0, 32'h0});
    chk("order_2", rsp_q[base + 2], {1'b0, 1'b0, 1'b0, 32'hA5});
    chk("order_3", rsp_q[base + 3], {1'b0, 1'b0, 1'b0, 32'h5A});
    chk("order_4", rsp_q[base + 4], {1'b1, 1'b0, 1'b0, 32'h0});

    // three wait states on a read of 0x4
    base     = rsp_q.size();
    slv_wait = 3;
    push(1'b0, 32'h4, 32'h0);
    wait_access();
    acc = 0;
    for (int i = 0; i < 40 && bus.PSEL && bus.PENABLE; i++) begin
      acc++;
      chk("wait_paddr",  35'(bus.PADDR),  35'(32'h4));
      chk("wait_pwrite", 35'(bus.PWRITE), 35'(0));
      step();
    end
    chk("wait_access_cycles", 35'(acc), 35'(4));
    wait_rsp(base + 1);
    chk("wait_rsp", rsp_q[base], {1'b0, 1'b0, 1'b0, 32'h1});
    slv_wait = 0;

    // completer error on a write
    base    = rsp_q.size();
    slv_err = 1'b1;
    push(1'b1, 32'hC, 32'h77);
    wait_rsp(base + 1);
    chk("slverr_rsp", rsp_q[base], {1'b1, 1'b1, 1'b0, 32'h0});
    slv_err = 1'b0;

    // completer never ready: forced termination after 16 ACCESS cycles
    base     = rsp_q.size();
    slv_hang = 1'b1;
    push(1'b1, 32'h10, 32'h99);
    wait_access();
    acc = 0;
    for (int i = 0; i < 60 && bus.PSEL && bus.PENABLE; i++) begin
      acc++;
      step();
    end
    chk("timeout_cycles", 35'(acc), 35'(16));
    chk("timeout_idle", 35'({bus.PSEL, bus.PENABLE}), 35'(2'b00));
    wait_rsp(base + 1);
    chk("timeout_rsp", rsp_q[base], {1'b1, 1'b1, 1'b1, 32'h0});
    slv_hang = 1'b0;

    // held response, then reset during the second transfer
    base          = rsp_q.size();
    slv_wait      = 5;
    bus.rsp_ready = 1'b0;
    push(1'b1, 32'h30, 32'h11);
    push(1'b0, 32'h30, 32'h0);
    push(1'b1, 32'h34, 32'h22);
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("held_rsp_valid", 35'(bus.rsp_valid), 35'(1));
      chk("held_rsp", {bus.rsp_write, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
          {1'b1, 1'b0, 1'b0, 32'h0});
      chk("held_no_start", 35'(bus.PSEL), 35'(0));
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("held_taken", 35'(rsp_q.size()), 35'(base + 1));
    chk("held_rsp_log", rsp_q[base], {1'b1, 1'b0, 1'b0, 32'h0});
    wait_access();
    chk("second_paddr", 35'(bus.PADDR), 35'(32'h30));
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("abort_psel_en",   35'({bus.PSEL, bus.PENABLE}), 35'(2'b00));
    chk("abort_rsp_valid", 35'(bus.rsp_valid), 35'(0));
    chk("abort_cmd_ready", 35'(bus.cmd_ready), 35'(1));
    chk("abort_paddr",     35'(bus.PADDR),     35'(0));
    for (int i = 0; i < 10; i++) begin
      chk("post_psel",      35'(bus.PSEL),      35'(0));
      chk("post_rsp_valid", 35'(bus.rsp_valid), 35'(0));
      step();
    end
    chk("post_no_rsp", 35'(rsp_q.size()), 35'(base + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // guard against a stuck sequence
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
